// File: rtl/max7219_spi_receiver.sv
// SPI mode-0 slave modelling the receive side of a MAX7219 display driver.
// Oversamples mosi/cs/clk_spi in the clk domain, assembles 16-bit frames and updates the register file.
module max7219_spi_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mosi,
  input  logic        cs,
  input  logic        clk_spi,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        err_short,
  output logic        err_long
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] mosi_sync, cs_sync, sclk_sync;
  logic                   mosi_s, cs_s, sclk_s;
  logic                   cs_d, sclk_d;
  logic                   cs_fall, cs_rise, sclk_rise;
  logic                   clr_cnt, shift_en, do_check;
  logic [15:0]            shreg;
  logic [4:0]             bit_cnt;
  logic [2:0]             digit_idx;

  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  // Addresses 1..8 wrap to digit indices 0..7 in three bits.
  assign digit_idx = shreg[10:8] - 3'd1;

  // Clearing cs history to 0 means a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], clk_spi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_cnt    = 1'b0;
    shift_en   = 1'b0;
    do_check   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          clr_cnt    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) state_next = CHECK;
        else if (sclk_rise && !cs_s) shift_en = 1'b1;
      end
      CHECK: begin
        do_check = 1'b1;
        if (cs_fall) begin
          state_next = SHIFT;
          clr_cnt    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[14:0], mosi_s};
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Commit stage: register file, last-frame echo and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      frame_valid  <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      if (do_check) begin
        if (bit_cnt < 5'd16) begin
          err_short <= 1'b1;
        end else begin
          frame_valid <= 1'b1;
          err_long    <= (bit_cnt > 5'd16);
          frame_addr  <= shreg[11:8];
          frame_data  <= shreg[7:0];
          case (shreg[11:8])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digits[{digit_idx, 3'b000} +: 8] <= shreg[7:0];
            4'h9:    decode_mode  <= shreg[7:0];
            4'hA:    intensity    <= shreg[3:0];
            4'hB:    scan_limit   <= shreg[2:0];
            4'hC:    shutdown_n   <= shreg[0];
            4'hF:    display_test <= shreg[0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Scoreboard bench for max7219_spi_receiver: directed frames push expected status into a queue,
// a negedge monitor pops and compares on every frame_valid/err pulse.
module tb_max7219_spi_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        clk_spi = 1'b0;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        err_short;
  logic        err_long;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       l;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  max7219_spi_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mosi(mosi), .cs(cs), .clk_spi(clk_spi),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
    .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every status pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || err_short || err_long)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got v=%b s=%b l=%b addr=%0h data=%0h expected none",
                 frame_valid, err_short, err_long, frame_addr, frame_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pulse_flags", {61'd0, frame_valid, err_short, err_long}, {61'd0, e.v, e.s, e.l});
        checkOutput("frame_addr_data", {52'd0, frame_addr, frame_data}, {52'd0, e.a, e.d});
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] frame, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi = frame[i];
      wait_clks(4);
      clk_spi = 1'b1;
      wait_clks(4);
      clk_spi = 1'b0;
    end
  endtask

  // Full frame at clk_spi = clk/8 with the expected status queued first.
  task automatic applyStimulus(input logic [31:0] frame, input int nbits,
                               input logic v, input logic s, input logic l,
                               input logic [3:0] a, input logic [7:0] d);
    sb.push_back('{v: v, s: s, l: l, a: a, d: d});
    cs = 1'b0;
    wait_clks(4);
    send_bits(frame, nbits - 1, 0);
    wait_clks(4);
    cs = 1'b1;
    wait_clks(8);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      wait_clks(1);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_digits"}, digits, 64'd0);
    checkOutput({tag, "_ctrl"}, {45'd0, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                64'd0);
    checkOutput({tag, "_frame"}, {49'd0, frame_valid, frame_addr, frame_data, err_short, err_long},
                64'd0);
  endtask

  initial begin
    wait_clks(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clks(8);

    applyStimulus(32'h0A05, 16, 1'b1, 1'b0, 1'b0, 4'hA, 8'h05);
    wait_drain();
    checkOutput("intensity_5", {60'd0, intensity}, 64'd5);

    applyStimulus(32'h0C01, 16, 1'b1, 1'b0, 1'b0, 4'hC, 8'h01);
    applyStimulus(32'h017E, 16, 1'b1, 1'b0, 1'b0, 4'h1, 8'h7E);
    applyStimulus(32'h0830, 16, 1'b1, 1'b0, 1'b0, 4'h8, 8'h30);
    applyStimulus(32'h0B07, 16, 1'b1, 1'b0, 1'b0, 4'hB, 8'h07);
    wait_drain();
    checkOutput("shutdown_n", {63'd0, shutdown_n}, 64'd1);
    checkOutput("digits_0_7", digits, 64'h3000_0000_0000_007E);
    checkOutput("scan_limit", {61'd0, scan_limit}, 64'd7);

    applyStimulus(32'h0A3, 12, 1'b0, 1'b1, 1'b0, 4'hB, 8'h07);
    wait_drain();
    checkOutput("intensity_after_short", {60'd0, intensity}, 64'd5);
    applyStimulus(32'h0903, 16, 1'b1, 1'b0, 1'b0, 4'h9, 8'h03);
    wait_drain();
    checkOutput("decode_mode", {56'd0, decode_mode}, 64'h03);

    applyStimulus(32'hFF037E, 24, 1'b1, 1'b0, 1'b1, 4'h3, 8'h7E);
    wait_drain();
    checkOutput("digits_long", digits, 64'h3000_0000_007E_007E);

    applyStimulus(32'h0D55, 16, 1'b1, 1'b0, 1'b0, 4'hD, 8'h55);
    wait_drain();
    checkOutput("noop_regs", {digits[63:8], decode_mode, intensity, scan_limit, shutdown_n},
                {56'h30_0000_0000_7E00, 8'h03, 4'h5, 3'h7, 1'b1});
    applyStimulus(32'h0F01, 16, 1'b1, 1'b0, 1'b0, 4'hF, 8'h01);
    wait_drain();
    checkOutput("display_test", {63'd0, display_test}, 64'd1);

    // Reset in the middle of a frame; the tail of that frame must be ignored.
    cs = 1'b0;
    wait_clks(4);
    send_bits(32'h0AFF, 15, 8);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    check_all_zero("midreset");
    send_bits(32'h0AFF, 7, 0);
    wait_clks(4);
    cs = 1'b1;
    wait_clks(12);
    check_all_zero("after_abort");

    applyStimulus(32'h0A02, 16, 1'b1, 1'b0, 1'b0, 4'hA, 8'h02);
    wait_drain();
    checkOutput("intensity_2", {60'd0, intensity}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
